// File: rtl/logic_axi4_stream_downsizer_if.sv
// logic_axi4_stream_downsizer_if: wide rx and narrow tx AXI4-Stream channels of the downsizer.
interface logic_axi4_stream_downsizer_if #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
);
    logic                   rx_tvalid;
    logic [WIDTH*RATIO-1:0] rx_tdata;
    logic [RATIO-1:0]       rx_tkeep;
    logic                   rx_tlast;
    logic                   rx_tready;
    logic                   tx_tvalid;
    logic [WIDTH-1:0]       tx_tdata;
    logic                   tx_tlast;
    logic                   tx_tready;
    modport slave (
        input  rx_tvalid, rx_tdata, rx_tkeep, rx_tlast, tx_tready,
        output rx_tready, tx_tvalid, tx_tdata, tx_tlast
    );
    modport master (
        output rx_tvalid, rx_tdata, rx_tkeep, rx_tlast, tx_tready,
        input  rx_tready, tx_tvalid, tx_tdata, tx_tlast
    );
endinterface

// File: rtl/logic_axi4_stream_downsizer.sv
// logic_axi4_stream_downsizer: serializes RATIO-lane AXI4-Stream beats into WIDTH-bit beats, lane 0 first.
// Define LOGIC_AXI4_STREAM_DOWNSIZER_TKEEP_EN to honour rx_tkeep; otherwise every lane is emitted.
module logic_axi4_stream_downsizer #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input logic                         aclk,
    input logic                         reset,
    logic_axi4_stream_downsizer_if.slave bus
);
    localparam int IW = $clog2(RATIO);
    typedef enum logic {EMPTY, SHIFT} state_t;
    state_t                 state_q, state_d;
    logic [WIDTH*RATIO-1:0] data_q;
    logic [RATIO-1:0]       keep_q, keep_eff;
    logic                   last_q, busy_q, final_lane, rx_hs, tx_hs;
    logic [IW-1:0]          idx_q, idx_d, idx_next, idx_first;

    if (RATIO < 2 || WIDTH < 1) begin : g_drc
        $error("logic_axi4_stream_downsizer: RATIO must be >= 2 and WIDTH >= 1");
    end

`ifdef LOGIC_AXI4_STREAM_DOWNSIZER_TKEEP_EN
    // an empty terminating beat still carries tlast out on lane 0
    assign keep_eff = (bus.rx_tkeep == '0) ? {{(RATIO-1){1'b0}}, bus.rx_tlast} : bus.rx_tkeep;
`else
    logic unused_keep;
    assign unused_keep = ^bus.rx_tkeep;
    assign keep_eff = '1;
`endif

    always_comb begin
        final_lane = 1'b1;
        idx_next = idx_q;
        idx_first = '0;
        for (int i = RATIO - 1; i >= 0; i--) begin
            if (keep_q[i] && i > int'(idx_q)) begin
                final_lane = 1'b0;
                idx_next = IW'(i);
            end
            if (keep_eff[i]) idx_first = IW'(i);
        end
    end

    assign busy_q = (state_q == SHIFT);
    assign bus.tx_tvalid = busy_q;
    assign bus.tx_tdata = data_q[int'(idx_q)*WIDTH +: WIDTH];
    assign bus.tx_tlast = busy_q & last_q & final_lane;
    // combinational from tx_tready so a new wide beat lands as the final lane leaves
    assign bus.rx_tready = !busy_q | (bus.tx_tready & final_lane);
    assign rx_hs = bus.rx_tvalid & bus.rx_tready;
    assign tx_hs = busy_q & bus.tx_tready;

    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        if (rx_hs) begin
            state_d = (keep_eff == '0) ? EMPTY : SHIFT;
            idx_d = idx_first;
        end else if (tx_hs) begin
            state_d = final_lane ? EMPTY : SHIFT;
            idx_d = final_lane ? idx_q : idx_next;
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q <= EMPTY;
            idx_q <= '0;
            keep_q <= '0;
            last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            if (rx_hs) begin
                keep_q <= keep_eff;
                last_q <= bus.rx_tlast;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (rx_hs) data_q <= bus.rx_tdata;
    end
endmodule

// File: tb/tb_logic_axi4_stream_downsizer.sv
// tb_logic_axi4_stream_downsizer: scoreboard bench for the 4x8-bit downsizer in either tkeep build.
module tb_logic_axi4_stream_downsizer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    int n_tx = 0;
    int n0;
    bit done;
    logic [8:0] q[$];
    logic [8:0] exp_item;

    logic_axi4_stream_downsizer_if #(.WIDTH(8), .RATIO(4)) bus ();
    logic_axi4_stream_downsizer #(.WIDTH(8), .RATIO(4)) dut (.aclk(clk), .reset(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // expected narrow beats of one accepted wide beat
    task automatic push_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        logic [3:0] ke;
        int hi;
`ifdef LOGIC_AXI4_STREAM_DOWNSIZER_TKEEP_EN
        ke = (k == 4'h0) ? {3'b000, l} : k;
`else
        ke = 4'hF;
`endif
        hi = -1;
        for (int i = 0; i < 4; i++) if (ke[i]) hi = i;
        for (int i = 0; i < 4; i++) if (ke[i]) q.push_back({l && i == hi, d[i*8 +: 8]});
    endtask

    always @(negedge clk) begin
        if (rst) q.delete();
        else begin
            if (bus.tx_tvalid && bus.tx_tready) begin
                if (q.size() == 0) check("tx_spurious", {31'b0, bus.tx_tvalid}, 32'd0);
                else begin
                    exp_item = q.pop_front();
                    check("tx_data", {24'b0, bus.tx_tdata}, {24'b0, exp_item[7:0]});
                    check("tx_last", {31'b0, bus.tx_tlast}, {31'b0, exp_item[8]});
                    n_tx++;
                end
            end
            if (bus.rx_tvalid && bus.rx_tready) push_beat(bus.rx_tdata, bus.rx_tkeep, bus.rx_tlast);
        end
    end

    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
        bus.rx_tvalid = 1'b1;
        bus.rx_tdata = d;
        bus.rx_tkeep = k;
        bus.rx_tlast = l;
        for (int t = 0; t <= 200; t++) begin
            @(negedge clk);
            if (bus.rx_tready) break;
            if (t == 200) check("send_timeout", {31'b0, bus.rx_tready}, 32'd1);
        end
        @(posedge clk) #1;
        bus.rx_tvalid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && (q.size() != 0 || bus.tx_tvalid); t++) @(negedge clk) #1;
        check("drain", q.size(), 32'd0);
        @(posedge clk) #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.rx_tvalid = 1'b0;
        bus.rx_tdata = '0;
        bus.rx_tkeep = '0;
        bus.rx_tlast = 1'b0;
        bus.tx_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_tvalid", {31'b0, bus.tx_tvalid}, 32'd0);
        check("rst_tlast", {31'b0, bus.tx_tlast}, 32'd0);
        check("rst_rready", {31'b0, bus.rx_tready}, 32'd1);
        @(posedge clk) #1;

        n0 = n_tx;
        send(32'h44332211, 4'hF, 1'b1);
        @(negedge clk);
        check("lat_valid", {31'b0, bus.tx_tvalid}, 32'd1);
        check("lat_data", {24'b0, bus.tx_tdata}, 32'h11);
        drain();
        check("full_beats", n_tx - n0, 32'd4);

        fork
            begin
                send(32'h04030201, 4'hF, 1'b0);
                send(32'h08070605, 4'hF, 1'b1);
            end
            begin
                for (int t = 0; t < 20 && !bus.tx_tvalid; t++) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    check("b2b_valid", {31'b0, bus.tx_tvalid}, 32'd1);
                    if (k == 3) check("b2b_rready", {31'b0, bus.rx_tready}, 32'd1);
                    @(negedge clk);
                end
            end
        join
        drain();

        n0 = n_tx;
        send(32'hDDCCBBAA, 4'b0101, 1'b1);
        drain();
`ifdef LOGIC_AXI4_STREAM_DOWNSIZER_TKEEP_EN
        check("sparse_beats", n_tx - n0, 32'd2);
`else
        check("sparse_beats", n_tx - n0, 32'd4);
`endif

        send(32'h88776655, 4'hF, 1'b1);
        @(negedge clk);
        @(posedge clk) #1 bus.tx_tready = 1'b0;
        @(negedge clk);
        check("stall_data0", {24'b0, bus.tx_tdata}, 32'h66);
        check("stall_rready0", {31'b0, bus.rx_tready}, 32'd0);
        @(negedge clk);
        check("stall_data1", {24'b0, bus.tx_tdata}, 32'h66);
        check("stall_valid", {31'b0, bus.tx_tvalid}, 32'd1);
        check("stall_rready1", {31'b0, bus.rx_tready}, 32'd0);
        @(posedge clk) #1 bus.tx_tready = 1'b1;
        drain();

        n0 = n_tx;
        send(32'h12345678, 4'h0, 1'b0);
`ifdef LOGIC_AXI4_STREAM_DOWNSIZER_TKEEP_EN
        @(negedge clk);
        check("zk_none", {31'b0, bus.tx_tvalid}, 32'd0);
        @(posedge clk) #1;
`endif
        send(32'h9ABCDEF0, 4'h0, 1'b1);
        drain();
`ifdef LOGIC_AXI4_STREAM_DOWNSIZER_TKEEP_EN
        check("zk_beats", n_tx - n0, 32'd1);
`else
        check("zk_beats", n_tx - n0, 32'd8);
`endif

        send(32'h44332211, 4'hF, 1'b1);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk) #1 rst = 1'b1;
        @(posedge clk) #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", {31'b0, bus.tx_tvalid}, 32'd0);
        @(posedge clk) #1;
        send(32'hA1B2C3D4, 4'hF, 1'b0);
        @(negedge clk);
        check("midrst_lane0", {24'b0, bus.tx_tdata}, 32'hD4);
        drain();

        done = 1'b0;
        fork
            while (!done) begin
                @(posedge clk) #1;
                bus.tx_tready = 1'($urandom_range(0, 1));
            end
        join_none
        for (int i = 0; i < 20; i++) send($urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        done = 1'b1;
        repeat (2) @(posedge clk);
        #2 bus.tx_tready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
